// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//   Memory stage of a simple RISC-V style pipeline. Accepts one load or store
//   from execute, checks it for legality and alignment, issues it to data
//   memory and returns a registered completion pulse. Load data is extended
//   by width and sign.
//
// Ports
//   Clk_i, Rst_ni          clock, synchronous active-low reset
//   Valid_i / Ready_o      operation handshake from execute (Ready_o = IDLE)
//   Addr_i, StoreData_i    byte address and rs2 value
//   MemRead_i, MemWrite_i  direction (exactly one must be set)
//   Funct3_i               000 B, 001 H, 010 W, 100 BU, 101 HU
//   MemReq_o .. MemBe_o    data memory request (held while in WAIT)
//   MemAck_i, MemRData_i   memory completion pulse and read word
//   Done_o, LoadData_o,    one-cycle registered completion, result and error
//   Err_o
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        Clk_i,
    input  logic        Rst_ni,
    input  logic        Valid_i,
    output logic        Ready_o,
    input  logic [31:0] Addr_i,
    input  logic [31:0] StoreData_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  Funct3_i,
    output logic        MemReq_o,
    output logic        MemWe_o,
    output logic [31:0] MemAddr_o,
    output logic [31:0] MemWData_o,
    output logic [3:0]  MemBe_o,
    input  logic        MemAck_i,
    input  logic [31:0] MemRData_i,
    output logic        Done_o,
    output logic [31:0] LoadData_o,
    output logic        Err_o
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Latched operation context
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;

    // Memory request registers
    logic          we_q, we_d;
    logic [31:0]   maddr_q, maddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;

    // Completion registers
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   ldata_q, ldata_d;

    // ------------------------------------------------------------------
    // Decode of the incoming operation
    // ------------------------------------------------------------------
    logic        dir_any;
    logic        f3_legal;
    logic        aligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    assign dir_any = MemRead_i | MemWrite_i;

    always_comb begin
        f3_legal = 1'b0;
        if (MemRead_i && MemWrite_i) begin
            f3_legal = 1'b0;
        end else if (MemWrite_i) begin
            // Stores have no unsigned variants
            f3_legal = (Funct3_i == 3'b000) || (Funct3_i == 3'b001) ||
                       (Funct3_i == 3'b010);
        end else begin
            f3_legal = (Funct3_i == 3'b000) || (Funct3_i == 3'b001) ||
                       (Funct3_i == 3'b010) || (Funct3_i == 3'b100) ||
                       (Funct3_i == 3'b101);
        end
    end

    always_comb begin
        aligned   = 1'b0;
        be_new    = 4'b1111;
        wdata_new = StoreData_i;
        case (Funct3_i[1:0])
            2'b00: begin
                aligned   = 1'b1;
                be_new    = 4'b0001 << Addr_i[1:0];
                wdata_new = {4{StoreData_i[7:0]}};
            end
            2'b01: begin
                aligned   = ~Addr_i[0];
                be_new    = 4'b0011 << Addr_i[1:0];
                wdata_new = {2{StoreData_i[15:0]}};
            end
            2'b10: begin
                aligned   = (Addr_i[1:0] == 2'b00);
                be_new    = 4'b1111;
                wdata_new = StoreData_i;
            end
            default: begin
                aligned   = 1'b0;
                be_new    = 4'b1111;
                wdata_new = StoreData_i;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane selection and extension
    // ------------------------------------------------------------------
    logic [31:0] rshift;
    logic [31:0] ld_ext;

    assign rshift = MemRData_i >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{rshift[7]}}, rshift[7:0]};
            3'b100:  ld_ext = {24'h0, rshift[7:0]};
            3'b001:  ld_ext = {{16{rshift[15]}}, rshift[15:0]};
            3'b101:  ld_ext = {16'h0, rshift[15:0]};
            default: ld_ext = MemRData_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ldata_d = ldata_q;

        case (state_q)
            S_IDLE: begin
                // Valid with no direction is a bubble and is dropped
                if (Valid_i && dir_any) begin
                    f3_d  = Funct3_i;
                    off_d = Addr_i[1:0];
                    we_d  = MemWrite_i;
                    if (f3_legal && aligned) begin
                        maddr_d = {Addr_i[31:2], 2'b00};
                        wdata_d = wdata_new;
                        be_d    = be_new;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        // Rejected before reaching memory
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        ldata_d = 32'h0;
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                // Ack takes priority over the timeout on the last cycle
                if (MemAck_i) begin
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    ldata_d = we_q ? 32'h0 : ld_ext;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    ldata_d = 32'h0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_i) begin
        if (!Rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
            maddr_q <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ldata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ldata_q <= ldata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Ready_o    = (state_q == S_IDLE);
    assign MemReq_o   = (state_q == S_WAIT);
    assign MemWe_o    = we_q & (state_q == S_WAIT);
    assign MemAddr_o  = maddr_q;
    assign MemWData_o = wdata_q;
    assign MemBe_o    = be_q;
    assign Done_o     = done_q;
    assign Err_o      = err_q;
    assign LoadData_o = ldata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        Clk_i = 1'b0;
    logic        Rst_ni;
    logic        Valid_i;
    logic        Ready_o;
    logic [31:0] Addr_i;
    logic [31:0] StoreData_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [2:0]  Funct3_i;
    logic        MemReq_o;
    logic        MemWe_o;
    logic [31:0] MemAddr_o;
    logic [31:0] MemWData_o;
    logic [3:0]  MemBe_o;
    logic        MemAck_i;
    logic [31:0] MemRData_i;
    logic        Done_o;
    logic [31:0] LoadData_o;
    logic        Err_o;

    int n_chk  = 0;
    int n_fail = 0;

    load_store_unit #(.TIMEOUT_CYC(16)) dut (
        .Clk_i      (Clk_i),
        .Rst_ni     (Rst_ni),
        .Valid_i    (Valid_i),
        .Ready_o    (Ready_o),
        .Addr_i     (Addr_i),
        .StoreData_i(StoreData_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .Funct3_i   (Funct3_i),
        .MemReq_o   (MemReq_o),
        .MemWe_o    (MemWe_o),
        .MemAddr_o  (MemAddr_o),
        .MemWData_o (MemWData_o),
        .MemBe_o    (MemBe_o),
        .MemAck_i   (MemAck_i),
        .MemRData_i (MemRData_i),
        .Done_o     (Done_o),
        .LoadData_o (LoadData_o),
        .Err_o      (Err_o)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples move 1 time unit after the edge
    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"}, Ready_o, 1);
        chk({tag, ".req"},   MemReq_o, 0);
        chk({tag, ".we"},    MemWe_o, 0);
        chk({tag, ".done"},  Done_o, 0);
        chk({tag, ".err"},   Err_o, 0);
        chk({tag, ".addr"},  MemAddr_o, 0);
        chk({tag, ".wdata"}, MemWData_o, 0);
        chk({tag, ".ldata"}, LoadData_o, 0);
        chk({tag, ".be"},    MemBe_o, 0);
    endtask

    // One operation end to end. ack_at = WAIT cycle index (0-based) carrying
    // the ack; any value >= 16 means memory never answers.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rdata, input int ack_at);
        bit          legal, alg, timed_out;
        int          nbytes, off;
        logic [31:0] exp_be, exp_wd, exp_ld, v;

        if (rd && wr)  legal = 0;
        else if (wr)   legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
        else           legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);

        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off    = int'(addr % 4);
        alg    = (off % nbytes) == 0;
        exp_be = ((32'd1 << nbytes) - 1) << off;
        exp_wd = (nbytes == 1) ? sd[7:0] * 32'h0101_0101 :
                 (nbytes == 2) ? sd[15:0] * 32'h0001_0001 : sd;

        // Expected load value: pick the addressed bytes, then extend
        v = rdata / (32'd1 << (8 * off));
        if (nbytes == 1) begin
            v = v % 256;
            if (!f3[2] && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (nbytes == 2) begin
            v = v % 65536;
            if (!f3[2] && v >= 32768) v = v + 32'hFFFF_0000;
        end
        timed_out = (ack_at >= 16);
        exp_ld    = (wr || timed_out) ? 32'h0 : v;

        chk("pre.ready", Ready_o, 1);
        Valid_i = 1; MemRead_i = rd; MemWrite_i = wr; Funct3_i = f3;
        Addr_i = addr; StoreData_i = sd;
        tick();
        Valid_i = 0; MemRead_i = 0; MemWrite_i = 0;
        Addr_i = $urandom; StoreData_i = $urandom; Funct3_i = 3'($urandom);

        if (!rd && !wr) begin
            chk("ign.ready", Ready_o, 1);
            chk("ign.req",   MemReq_o, 0);
            chk("ign.done",  Done_o, 0);
            return;
        end

        if (!legal || !alg) begin
            chk("rej.req",   MemReq_o, 0);
            chk("rej.done",  Done_o, 1);
            chk("rej.err",   Err_o, 1);
            chk("rej.ldata", LoadData_o, 0);
            tick();
            chk("rej.done2",  Done_o, 0);
            chk("rej.ready2", Ready_o, 1);
            return;
        end

        for (int c = 0; c < 16; c++) begin
            chk("wait.req",   MemReq_o, 1);
            chk("wait.ready", Ready_o, 0);
            chk("wait.done",  Done_o, 0);
            chk("wait.we",    MemWe_o, wr);
            chk("wait.addr",  MemAddr_o, addr & 32'hFFFF_FFFC);
            chk("wait.be",    MemBe_o, exp_be);
            if (wr) chk("wait.wdata", MemWData_o, exp_wd);
            MemAck_i   = (c == ack_at);
            MemRData_i = (c == ack_at) ? rdata : $urandom;
            tick();
            MemAck_i = 0;
            if (c == ack_at) break;
        end

        chk("resp.done",  Done_o, 1);
        chk("resp.err",   Err_o, timed_out);
        chk("resp.ldata", LoadData_o, exp_ld);
        chk("resp.req",   MemReq_o, 0);
        tick();
        chk("post.done",  Done_o, 0);
        chk("post.ready", Ready_o, 1);
    endtask

    initial begin
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          ack;

        Rst_ni = 0; Valid_i = 0; Addr_i = 0; StoreData_i = 0;
        MemRead_i = 0; MemWrite_i = 0; Funct3_i = 0;
        MemAck_i = 0; MemRData_i = 0;
        tick(); tick();
        chk_reset_vals("rst");
        Rst_ni = 1;
        tick();

        // LB 0x1003 -> byte 0x80 sign-extended
        do_op(1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF7F, 0);
        // SH 0x2002 -> upper half lanes, replicated data
        do_op(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0, 0);
        // LW misaligned
        do_op(1, 0, 3'b010, 32'h3001, 32'h0, 32'h0, 0);
        // LHU with no ack -> timeout after 16 WAIT cycles
        do_op(1, 0, 3'b101, 32'h0002, 32'h0, 32'h0, 99);
        // LHU, ack on the last WAIT cycle wins
        do_op(1, 0, 3'b101, 32'h0002, 32'h0, 32'hBEEF_0000, 15);
        // Both directions, store unsigned variant, reserved funct3, bubble
        do_op(1, 1, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0);
        do_op(0, 1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0);
        do_op(1, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0);
        do_op(0, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0);

        // Reset in the middle of WAIT abandons the request
        Valid_i = 1; MemRead_i = 1; Funct3_i = 3'b010; Addr_i = 32'h40;
        tick();
        Valid_i = 0; MemRead_i = 0;
        chk("mid.req", MemReq_o, 1);
        tick();
        Rst_ni = 0;
        tick();
        chk_reset_vals("midrst");
        Rst_ni = 1;
        MemAck_i = 1; MemRData_i = 32'hDEAD_BEEF;
        tick();
        MemAck_i = 0;
        chk("midrst.done",  Done_o, 0);
        chk("midrst.ready", Ready_o, 1);
        chk("midrst.req",   MemReq_o, 0);
        tick();
        chk("midrst.done2", Done_o, 0);

        // Randomized operations with stray acks between them
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       begin rd = 0; wr = 0; end
                1:       begin rd = 1; wr = 1; end
                2, 3, 4: begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 0; end
            endcase
            f3  = 3'($urandom);
            a   = $urandom;
            ack = ($urandom_range(0, 5) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 3);
            do_op(rd, wr, f3, a, $urandom, $urandom, ack);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                MemAck_i = $urandom_range(0, 1);
                MemRData_i = $urandom;
                tick();
                MemAck_i = 0;
                chk("idle.done",  Done_o, 0);
                chk("idle.ready", Ready_o, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have a single clock and a reset that is synchronous and active-low: Clk_i, Rst_ni.
REQ-002 Parameter TIMEOUT_CYC SHALL default to 16 and sets the maximum number of cycles spent waiting for MemAck_i.
REQ-003 Ports SHALL be exactly as follows (name  direction  width  meaning):
- Clk_i  in  1  clock, rising edge
- Rst_ni  in  1  synchronous active-low reset
- Valid_i  in  1  execute stage presents a memory operation
- Ready_o  out  1  unit can accept an operation this cycle
- Addr_i  in  32  byte address, taken from the ALU add result
- StoreData_i  in  32  rs2 value to be stored
- MemRead_i  in  1  operation is a load
- MemWrite_i  in  1  operation is a store
- Funct3_i  in  3  width and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- MemReq_o  out  1  request to data memory
- MemWe_o  out  1  1 = write, 0 = read
- MemAddr_o  out  32  word-aligned address, with {Addr[31:2],2'b00}
- MemWData_o  out  32  store data shifted into the correct byte lanes
- MemBe_o  out  4  byte enables
- MemAck_i  in  1  memory completed the request (1-cycle pulse)
- MemRData_i  in  32  read word, valid when MemAck_i=1
- Done_o  out  1  1-cycle completion pulse to writeback
- LoadData_o  out  32  extended load result, valid while Done_o=1
- Err_o  out  1  misaligned, illegal or timed-out operation, valid while Done_o=1

Function
REQ-004 The FSM SHALL have three states: IDLE, WAIT and RESP. Ready_o SHALL be 1 only in IDLE.
REQ-005 In IDLE, Valid_i=1 with exactly one of MemRead_i or MemWrite_i set SHALL latch Addr_i, StoreData_i, Funct3_i and the direction. If the access is aligned, the FSM SHALL go to WAIT; otherwise it SHALL go to RESP with Err=1.
REQ-006 In IDLE, Valid_i=1 with neither MemRead_i nor MemWrite_i set SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-007 In IDLE, Valid_i=1 with both MemRead_i and MemWrite_i set, or with a Funct3_i code not listed in REQ-003, SHALL go to RESP with Err=1. No memory request SHALL be made.
REQ-008 Alignment rules: H/HU accesses need Addr[0]=0; W accesses need Addr[1:0]=00; B/BU accesses are always aligned. Stores SHALL allow only B, H and W.
REQ-009 In WAIT, MemReq_o SHALL be 1. MemWe_o, MemAddr_o, MemWData_o and MemBe_o SHALL come from registers and stay stable until MemAck_i. In every other state MemReq_o SHALL be 0.
REQ-010 Byte enables: B accesses use 4'b0001<<Addr[1:0]; H accesses use 4'b0011<<Addr[1:0]; W accesses use 4'b1111. Loads SHALL drive the same MemBe_o pattern.
REQ-011 MemWData_o SHALL be StoreData_i replicated across the lanes: B as {4{SD[7:0]}}, H as {2{SD[15:0]}}, W as SD.
REQ-012 In WAIT, MemAck_i=1 SHALL capture the lane-selected MemRData_i, then:
- sign-extend for B and H
- zero-extend for BU and HU
- pass the word through for W
The result SHALL be written to the LoadData register, and the FSM SHALL go to RESP with Err=0.
REQ-013 A stores-only result: for a store, LoadData_o SHALL be 32'h0.
REQ-014 A wait counter SHALL reset to 0 on entry to WAIT and increment each WAIT cycle without MemAck_i. When it reaches TIMEOUT_CYC-1 without an ack, the FSM SHALL go to RESP with Err=1 and LoadData=0.
REQ-015 If MemAck_i arrives in the same cycle the counter reaches TIMEOUT_CYC-1, the ack SHALL win and Err=0.
REQ-016 RESP SHALL last exactly one cycle with Done_o=1, then return to IDLE. Done_o, LoadData_o and Err_o SHALL be registered outputs.
REQ-017 A MemAck_i seen outside WAIT SHALL be ignored.
REQ-018 Latency SHALL be as follows:
- an aligned access with an ack in the first WAIT cycle gives Done_o 2 cycles after acceptance
- a misaligned or illegal access gives Done_o 1 cycle after acceptance

Reset
REQ-019 Rst_ni=0 at a clock edge SHALL force the following values:
- FSM to IDLE and the wait counter to 0
- Ready_o=1
- MemReq_o, MemWe_o, Done_o and Err_o to 0
- MemAddr_o, MemWData_o and LoadData_o to 32'h0
- MemBe_o=4'h0
REQ-020 A reset applied in the middle of WAIT SHALL abandon the request with no Done_o, and any later MemAck_i SHALL be ignored.

Verification
REQ-021 LB from Addr=0x1003 with RData=0x80FF_FF7F and an ack in the first WAIT cycle SHALL give MemAddr_o=0x1000, MemBe_o=4'b1000, then Done_o=1, LoadData_o=0xFFFF_FF80 and Err_o=0.
REQ-022 SH from Addr=0x2002 with StoreData=0x1234_ABCD SHALL give MemWe_o=1, MemBe_o=4'b1100, MemWData_o=0xABCD_ABCD, then Done_o=1 with LoadData_o=0.
REQ-023 LW from Addr=0x3001 SHALL produce no MemReq_o, then Done_o=1 and Err_o=1 one cycle after acceptance.
REQ-024 LHU from Addr=0x0002 with no ack SHALL keep MemReq_o high for 16 cycles, then give Done_o=1, Err_o=1 and LoadData_o=0.
REQ-025 An ack on the 16th WAIT cycle, with RData=0xBEEF_0000 for LHU at Addr=2, SHALL give Err_o=0 and LoadData_o=0x0000_BEEF.
REQ-026 Asserting Rst_ni=0 during WAIT, then sending MemAck_i after reset, SHALL give no Done_o and Ready_o=1.
